mem_stage: RTL and testbench

//  Pipeline stage directly downstream of the ALU/execute stage. Registers the execute-stage

---
 rtl/mem_stage_pkg.sv | 33 +++
 rtl/mem_stage_handshake.sv | 103 ++++++++++
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: opcodes, handshake states, sizes.
package mem_stage_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_REG_AW  = 3;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned CNT_W       = 8;

    localparam logic [OP_W-1:0] OP_ALU  = 3'b000;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b001;
    localparam logic [OP_W-1:0] OP_LUI  = 3'b011;
    localparam logic [OP_W-1:0] OP_SW   = 3'b100;
    localparam logic [OP_W-1:0] OP_LW   = 3'b101;
    localparam logic [OP_W-1:0] OP_BR   = 3'b110;
    localparam logic [OP_W-1:0] OP_JALR = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } hs_state_e;

    // Opcodes that produce a register result without touching memory.
    function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
        return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LUI) || (op == OP_JALR);
    endfunction

    // Opcodes that need a data-memory access.
    function automatic logic op_is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_handshake.sv
// Data-memory req/ack sequencer with timeout abort and sticky bus error.
module mem_handshake
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              bus_err_o,
    output logic              done_c,
    output logic              abort_c
);

    hs_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    // State and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state: launch on start, finish on ack, abort after TIMEOUT unacked WAIT cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        done_c  = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end
            end
            S_WAIT: begin
                if (mem_ack_i) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    abort_c = 1'b1;
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q == S_WAIT);
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign bus_err_o   = err_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers execute results for writeback, runs lw/sw, drives bypass.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned REG_AW  = DEF_REG_AW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [REG_AW-1:0] in_tgt,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_tgt,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_tgt,
    output logic [DATA_W-1:0] fwd_data,
    output logic              bus_err
);

    logic hs_busy, hs_done_c, hs_abort_c;
    logic accept_c, is_mem_c, start_c, lw_wait_c;

    logic              wb_we_q, wb_we_d;
    logic [REG_AW-1:0] wb_tgt_q, wb_tgt_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [REG_AW-1:0] fwd_tgt_q, fwd_tgt_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              pend_lw_q, pend_lw_d;
    logic [REG_AW-1:0] pend_tgt_q, pend_tgt_d;

    assign accept_c = !hs_busy && in_valid;
    assign is_mem_c = op_is_mem(in_op);
    assign start_c  = accept_c && is_mem_c;

    mem_handshake #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_c),
        .we_i        (in_op == OP_SW),
        .addr_i      (in_result),
        .wdata_i     (in_sdata),
        .mem_ack_i   (mem_ack),
        .busy_o      (hs_busy),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .bus_err_o   (bus_err),
        .done_c      (hs_done_c),
        .abort_c     (hs_abort_c)
    );

    // Writeback, bypass and pending-load registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we_q     <= 1'b0;
            wb_tgt_q    <= '0;
            wb_data_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_tgt_q   <= '0;
            fwd_data_q  <= '0;
            pend_lw_q   <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            wb_we_q     <= wb_we_d;
            wb_tgt_q    <= wb_tgt_d;
            wb_data_q   <= wb_data_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_tgt_q   <= fwd_tgt_d;
            fwd_data_q  <= fwd_data_d;
            pend_lw_q   <= pend_lw_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

    // Writeback selection: completed/aborted load, or a direct result from execute.
    always_comb begin
        wb_we_d    = 1'b0;
        wb_tgt_d   = wb_tgt_q;
        wb_data_d  = wb_data_q;
        pend_lw_d  = pend_lw_q;
        pend_tgt_d = pend_tgt_q;
        if (hs_done_c) begin
            if (pend_lw_q) begin
                wb_we_d   = (pend_tgt_q != '0);
                wb_tgt_d  = pend_tgt_q;
                wb_data_d = mem_rdata;
            end
        end else if (hs_abort_c) begin
            if (pend_lw_q) begin
                wb_we_d   = (pend_tgt_q != '0);
                wb_tgt_d  = pend_tgt_q;
                wb_data_d = '0;
            end
        end else if (accept_c) begin
            if (is_mem_c) begin
                pend_lw_d  = (in_op == OP_LW);
                pend_tgt_d = in_tgt;
            end else begin
                wb_we_d   = op_writes_reg(in_op) && (in_tgt != '0);
                wb_tgt_d  = in_tgt;
                wb_data_d = in_result;
            end
        end
    end

    // Bypass mirrors writeback, except a load in flight advertises its target as not-ready.
    always_comb begin
        lw_wait_c   = (start_c && (in_op == OP_LW)) ||
                      (hs_busy && pend_lw_q && !hs_done_c && !hs_abort_c);
        fwd_valid_d = wb_we_d;
        fwd_tgt_d   = lw_wait_c ? pend_tgt_d : wb_tgt_d;
        fwd_data_d  = wb_data_d;
    end

    assign stall     = hs_busy;
    assign wb_we     = wb_we_q;
    assign wb_tgt    = wb_tgt_q;
    assign wb_data   = wb_data_q;
    assign fwd_valid = fwd_valid_q;
    assign fwd_tgt   = fwd_tgt_q;
    assign fwd_data  = fwd_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage with a transaction-level expectation model.
module tb_mem_stage;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [15:0] in_result;
    logic [15:0] in_sdata;
    logic [2:0]  in_tgt;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wb_we;
    logic [2:0]  wb_tgt;
    logic [15:0] wb_data;
    logic        fwd_valid;
    logic [2:0]  fwd_tgt;
    logic [15:0] fwd_data;
    logic        bus_err;

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_result (in_result),
        .in_sdata  (in_sdata),
        .in_tgt    (in_tgt),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_we     (wb_we),
        .wb_tgt    (wb_tgt),
        .wb_data   (wb_data),
        .fwd_valid (fwd_valid),
        .fwd_tgt   (fwd_tgt),
        .fwd_data  (fwd_data),
        .bus_err   (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Expected architectural view of the stage outputs.
    logic [2:0]  exp_tgt;
    logic [15:0] exp_data;
    logic [2:0]  exp_ftgt;
    logic        exp_err;

    function automatic bit ref_writes(input logic [2:0] op, input logic [2:0] tgt);
        bit w;
        case (op)
            3'd0, 3'd1, 3'd3, 3'd7: w = 1'b1;
            default:                w = 1'b0;
        endcase
        return w && (tgt != 3'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_core(input string tag, input logic e_stall, input logic e_req, input logic e_we);
        chk({tag, ".stall"},     32'(stall),     32'(e_stall));
        chk({tag, ".mem_req"},   32'(mem_req),   32'(e_req));
        chk({tag, ".wb_we"},     32'(wb_we),     32'(e_we));
        chk({tag, ".wb_tgt"},    32'(wb_tgt),    32'(exp_tgt));
        chk({tag, ".wb_data"},   32'(wb_data),   32'(exp_data));
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(e_we));
        chk({tag, ".fwd_tgt"},   32'(fwd_tgt),   32'(exp_ftgt));
        chk({tag, ".fwd_data"},  32'(fwd_data),  32'(exp_data));
        chk({tag, ".bus_err"},   32'(bus_err),   32'(exp_err));
    endtask

    task automatic chk_zero(input string tag);
        exp_tgt  = '0;
        exp_data = '0;
        exp_ftgt = '0;
        exp_err  = 1'b0;
        chk_core(tag, 1'b0, 1'b0, 1'b0);
        chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // One non-memory instruction (or bubble); called and returns at a negedge.
    task automatic alu_step(input logic v, input logic [2:0] op, input logic [2:0] tgt,
                            input logic [15:0] res);
        in_valid  = v;
        in_op     = op;
        in_tgt    = tgt;
        in_result = res;
        in_sdata  = 16'($urandom);
        mem_ack   = 1'($urandom);
        mem_rdata = 16'($urandom);
        @(negedge clk);
        if (v) begin
            exp_tgt  = tgt;
            exp_data = res;
        end
        exp_ftgt = exp_tgt;
        chk_core("alu", 1'b0, 1'b0, v && ref_writes(op, tgt));
        in_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    // One lw/sw; delay = number of unacked WAIT cycles before ack, negative = never ack.
    task automatic mem_step(input bit is_lw, input logic [15:0] addr, input logic [15:0] data,
                            input logic [2:0] tgt, input int delay, input logic [15:0] rdata,
                            input bit follow);
        logic [2:0]  ftgt;
        logic [15:0] fres;
        int          nreq;
        ftgt      = 3'($urandom);
        fres      = 16'($urandom);
        nreq      = (delay < 0) ? TIMEOUT : delay + 1;
        in_valid  = 1'b1;
        in_op     = is_lw ? 3'b101 : 3'b100;
        in_result = addr;
        in_sdata  = data;
        in_tgt    = tgt;
        mem_ack   = 1'b0;
        for (int k = 0; k < nreq; k++) begin
            @(negedge clk);
            if (follow) begin
                in_valid  = 1'b1;
                in_op     = 3'b001;
                in_tgt    = ftgt;
                in_result = fres;
            end else begin
                in_valid  = 1'($urandom);
                in_op     = 3'($urandom);
                in_tgt    = 3'($urandom);
                in_result = 16'($urandom);
            end
            exp_ftgt = is_lw ? tgt : exp_tgt;
            chk_core("wait", 1'b1, 1'b1, 1'b0);
            chk("wait.mem_we",    32'(mem_we),    32'(!is_lw));
            chk("wait.mem_addr",  32'(mem_addr),  32'(addr));
            chk("wait.mem_wdata", 32'(mem_wdata), 32'(data));
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rdata : 16'($urandom);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (delay < 0) exp_err = 1'b1;
        if (is_lw) begin
            exp_tgt  = tgt;
            exp_data = (delay < 0) ? 16'h0000 : rdata;
        end
        exp_ftgt = exp_tgt;
        chk_core("done", 1'b0, 1'b0, is_lw && (tgt != 3'd0));
        if (follow) begin
            @(negedge clk);
            exp_tgt  = ftgt;
            exp_data = fres;
            exp_ftgt = ftgt;
            chk_core("held", 1'b0, 1'b0, ftgt != 3'd0);
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [2:0] rand_alu_op();
        logic [2:0] ops [6];
        ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        return ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_op     = 3'b101;
        in_result = 16'h1111;
        in_sdata  = 16'h2222;
        in_tgt    = 3'd4;
        mem_ack   = 1'b1;
        mem_rdata = 16'h3333;
        exp_tgt   = '0;
        exp_data  = '0;
        exp_ftgt  = '0;
        exp_err   = 1'b0;

        // Reset window with live input traffic, then the cycle after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero("reset");
            in_op     = 3'($urandom);
            in_result = 16'($urandom);
            in_tgt    = 3'($urandom);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
        chk_zero("post_reset");

        // addi writes, r0 suppressed.
        alu_step(1'b1, 3'b001, 3'd3, 16'h1234);
        alu_step(1'b1, 3'b001, 3'd0, 16'h1234);

        // Random non-memory ops and bubbles, with stray mem_ack outside WAIT.
        for (int i = 0; i < 30; i++)
            alu_step(1'($urandom_range(0, 3) != 0), rand_alu_op(), 3'($urandom), 16'($urandom));

        // lw acked after 3 idle WAIT cycles, with an addi held behind it.
        mem_step(1'b1, 16'h0040, 16'($urandom), 3'(1 + $urandom_range(0, 6)), 3, 16'hBEEF, 1'b1);

        // sw to top of address space acked in its first request cycle.
        mem_step(1'b0, 16'hFFFF, 16'h00A5, 3'($urandom), 0, 16'($urandom), 1'b0);

        // Random memory traffic interleaved with ALU ops.
        for (int i = 0; i < 12; i++) begin
            mem_step(1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                     $urandom_range(0, 4), 16'($urandom), 1'($urandom));
            alu_step(1'b1, rand_alu_op(), 3'($urandom), 16'($urandom));
        end

        // Timed-out lw writes zero and sets the sticky error; a timed-out sw writes nothing.
        mem_step(1'b1, 16'h0100, 16'h0000, 3'd6, -1, 16'h0000, 1'b0);
        mem_step(1'b0, 16'h0200, 16'h5A5A, 3'd2, -1, 16'h0000, 1'b0);
        // A later good lw keeps bus_err set.
        mem_step(1'b1, 16'h0300, 16'h0000, 3'd5, 2, 16'hC0DE, 1'b0);
        alu_step(1'b1, 3'b011, 3'd7, 16'hABCD);

        // Reset during the second WAIT cycle of a lw; a late ack must do nothing.
        in_valid  = 1'b1;
        in_op     = 3'b101;
        in_result = 16'h0400;
        in_tgt    = 3'd5;
        @(negedge clk);
        in_valid = 1'b0;
        exp_ftgt = 3'd5;
        chk_core("rst_wait1", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_core("rst_wait2", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_in_wait");
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk_zero("late_ack1");
        @(negedge clk);
        chk_zero("late_ack2");
        mem_ack = 1'b0;
        alu_step(1'b1, 3'b000, 3'd1, 16'h0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
